// File: rtl/axicb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axicb_pkg : shared types and helpers for the crossbar write-path blocks.
// Revision: 1.0
// ----------------------------------------------------------------------------
package axicb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } axicb_aw_state_t;

  // Width of a binary index into n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axicb_round_robin_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axicb_round_robin_core : one-hot round-robin grant with rotating priority mask.
// Revision: 1.0
// ----------------------------------------------------------------------------
module axicb_round_robin_core #(
  parameter int REQ_NB = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  input  logic [REQ_NB-1:0] i_req,
  input  logic              i_en,
  output logic [REQ_NB-1:0] o_grant
);

  localparam logic [REQ_NB-1:0] c_one = {{(REQ_NB-1){1'b0}}, 1'b1};

  logic [REQ_NB-1:0] r_mask;
  logic [REQ_NB-1:0] w_masked;
  logic [REQ_NB-1:0] w_pool;
  logic [REQ_NB-1:0] w_grant;
  logic [REQ_NB-1:0] w_next_mask;

  // Masked requests win first; with none left the unmasked set wraps around.
  always_comb begin
    w_masked    = i_req & r_mask;
    w_pool      = (|w_masked) ? w_masked : i_req;
    w_grant     = w_pool & (~w_pool + c_one);
    w_next_mask = ~(w_grant | (w_grant - c_one));
    if (w_next_mask == '0) begin
      w_next_mask = '1;
    end
  end

  assign o_grant = w_grant;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_mask <= '1;
    end else if (srst) begin
      r_mask <= '1;
    end else if (i_en && (|w_grant)) begin
      r_mask <= w_next_mask;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axicb_wr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axicb_wr_arbiter : AW arbitration with lock-until-handshake, W routed in AW order.
// Revision: 1.0
// ----------------------------------------------------------------------------
module axicb_wr_arbiter
  import axicb_pkg::*;
#(
  parameter int MST_NB          = 4,
  parameter int AWCH_W          = 64,
  parameter int WCH_W           = 72,
  parameter int MST_OSTDREQ_NUM = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     srst,
  input  logic [MST_NB-1:0]        i_awvalid,
  output logic [MST_NB-1:0]        i_awready,
  input  logic [MST_NB*AWCH_W-1:0] i_awch,
  output logic                     o_awvalid,
  input  logic                     o_awready,
  output logic [AWCH_W-1:0]        o_awch,
  input  logic [MST_NB-1:0]        i_wvalid,
  output logic [MST_NB-1:0]        i_wready,
  input  logic [MST_NB-1:0]        i_wlast,
  input  logic [MST_NB*WCH_W-1:0]  i_wch,
  output logic                     o_wvalid,
  input  logic                     o_wready,
  output logic                     o_wlast,
  output logic [WCH_W-1:0]         o_wch
);

  localparam int IDX_W = idx_width(MST_NB);
  localparam int PTR_W = idx_width(MST_OSTDREQ_NUM);
  localparam int CNT_W = $clog2(MST_OSTDREQ_NUM) + 1;
  localparam logic [CNT_W-1:0] c_full = CNT_W'(MST_OSTDREQ_NUM);

  axicb_aw_state_t   r_state;
  logic [MST_NB-1:0] r_sel;
  logic [IDX_W-1:0]  r_fifo [MST_OSTDREQ_NUM];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic [MST_NB-1:0] w_grant;
  logic              w_rr_en;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [IDX_W-1:0]  w_head;

  assign w_full  = (r_count == c_full);
  assign w_empty = (r_count == '0);
  assign w_rr_en = (r_state == IDLE) && (|w_grant) && !w_full;

  axicb_round_robin_core #(
    .REQ_NB (MST_NB)
  ) u_rr_core (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .i_req   (i_awvalid),
    .i_en    (w_rr_en),
    .o_grant (w_grant)
  );

  always_comb begin
    w_sel_idx = '0;
    for (int k = 0; k < MST_NB; k++) begin
      if (r_sel[k]) begin
        w_sel_idx = w_sel_idx | IDX_W'(k);
      end
    end
  end

  // AW path is only opened in LOCKED, so no master's valid can reach another's ready.
  always_comb begin
    o_awvalid = 1'b0;
    o_awch    = '0;
    i_awready = '0;
    if (r_state == LOCKED) begin
      o_awvalid = |(i_awvalid & r_sel);
      i_awready = r_sel & {MST_NB{o_awready}};
      for (int k = 0; k < MST_NB; k++) begin
        if (r_sel[k]) begin
          o_awch = o_awch | i_awch[k*AWCH_W +: AWCH_W];
        end
      end
    end
  end

  assign w_push = (r_state == LOCKED) && o_awvalid && o_awready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_sel   <= '0;
    end else if (srst) begin
      r_state <= IDLE;
      r_sel   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rr_en) begin
            r_sel   <= w_grant;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_push) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_head = r_fifo[r_rptr];

  always_comb begin
    o_wvalid = 1'b0;
    o_wlast  = 1'b0;
    o_wch    = '0;
    i_wready = '0;
    if (!w_empty) begin
      for (int k = 0; k < MST_NB; k++) begin
        if (w_head == IDX_W'(k)) begin
          o_wvalid    = i_wvalid[k];
          o_wlast     = i_wlast[k];
          o_wch       = i_wch[k*WCH_W +: WCH_W];
          i_wready[k] = o_wready;
        end
      end
    end
  end

  assign w_pop = o_wvalid && o_wready && o_wlast;

  // Storage needs no reset: entries are only visible while the count is nonzero.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= w_sel_idx;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (srst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axicb_wr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_axicb_wr_arbiter : directed self-checking bench for axicb_wr_arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_axicb_wr_arbiter;

  localparam int MST_NB = 4;
  localparam int AWCH_W = 64;
  localparam int WCH_W  = 72;
  localparam int DEPTH  = 4;

  logic                     aclk    = 1'b0;
  logic                     aresetn = 1'b0;
  logic                     srst    = 1'b0;
  logic [MST_NB-1:0]        i_awvalid;
  logic [MST_NB-1:0]        i_awready;
  logic [MST_NB*AWCH_W-1:0] i_awch;
  logic                     o_awvalid;
  logic                     o_awready;
  logic [AWCH_W-1:0]        o_awch;
  logic [MST_NB-1:0]        i_wvalid;
  logic [MST_NB-1:0]        i_wready;
  logic [MST_NB-1:0]        i_wlast;
  logic [MST_NB*WCH_W-1:0]  i_wch;
  logic                     o_wvalid;
  logic                     o_wready;
  logic                     o_wlast;
  logic [WCH_W-1:0]         o_wch;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  axicb_wr_arbiter #(
    .MST_NB          (MST_NB),
    .AWCH_W          (AWCH_W),
    .WCH_W           (WCH_W),
    .MST_OSTDREQ_NUM (DEPTH)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .i_awvalid (i_awvalid),
    .i_awready (i_awready),
    .i_awch    (i_awch),
    .o_awvalid (o_awvalid),
    .o_awready (o_awready),
    .o_awch    (o_awch),
    .i_wvalid  (i_wvalid),
    .i_wready  (i_wready),
    .i_wlast   (i_wlast),
    .i_wch     (i_wch),
    .o_wvalid  (o_wvalid),
    .o_wready  (o_wready),
    .o_wlast   (o_wlast),
    .o_wch     (o_wch)
  );

  function automatic logic [63:0] awp(input int k);
    return 64'hA5A5_0000_0000_0000 + 64'(k);
  endfunction

  function automatic logic [71:0] wp(input int k);
    return 72'h3C_0000_0000_0000_0000 + 72'(k);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_aw(input string tag, input logic v, input logic [3:0] rdy, input logic [63:0] pay);
    chk({tag, "_awvalid"}, o_awvalid, v);
    chk({tag, "_awready"}, i_awready, rdy);
    chk({tag, "_awch"}, o_awch, pay);
  endtask

  task automatic chk_w(input string tag, input logic v, input logic [3:0] rdy, input logic l,
                       input logic [71:0] pay);
    chk({tag, "_wvalid"}, o_wvalid, v);
    chk({tag, "_wready"}, i_wready, rdy);
    chk({tag, "_wlast"}, o_wlast, l);
    chk({tag, "_wch"}, o_wch, pay);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    i_awvalid = '0;
    i_wvalid  = '0;
    i_wlast   = '0;
    o_awready = 1'b0;
    o_wready  = 1'b0;
  endtask

  task automatic do_srst();
    tick();
    idle_inputs();
    srst = 1'b1;
    tick();
    srst = 1'b0;
  endtask

  task automatic do_areset();
    tick();
    idle_inputs();
    #2 aresetn = 1'b0;
    #2 aresetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    for (int k = 0; k < MST_NB; k++) begin
      i_awch[k*AWCH_W +: AWCH_W] = awp(k);
      i_wch[k*WCH_W +: WCH_W]    = wp(k);
    end

    // Reset state: outputs stay low even with every master requesting.
    i_awvalid = 4'hF; i_wvalid = 4'hF; i_wlast = 4'hF; o_awready = 1'b1; o_wready = 1'b1;
    #3;
    chk_aw("rst", 1'b0, 4'b0000, 64'h0);
    chk_w("rst", 1'b0, 4'b0000, 1'b0, 72'h0);
    idle_inputs();
    #9 aresetn = 1'b1;
    tick();

    // All masters requesting, single-beat W each: AW and W in order 0,1,2,3,0.
    i_awvalid = 4'hF; i_wvalid = 4'hF; i_wlast = 4'hF; o_awready = 1'b1; o_wready = 1'b1;
    #1;
    chk("s1_first_idle_awvalid", o_awvalid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_aw($sformatf("s1_lock%0d", i), 1'b1, 4'(1 << (i % 4)), awp(i % 4));
      chk($sformatf("s1_lock%0d_wempty", i), o_wvalid, 1'b0);
      tick();
      chk($sformatf("s1_idle%0d_awvalid", i), o_awvalid, 1'b0);
      chk_w($sformatf("s1_w%0d", i), 1'b1, 4'(1 << (i % 4)), 1'b1, wp(i % 4));
    end
    i_awvalid = '0;
    tick();
    chk("s1_drained_wvalid", o_wvalid, 1'b0);
    do_srst();

    // Requests 0101 with slave stalling: master 0 held, then master 2 granted.
    i_awvalid = 4'b0101; o_awready = 1'b0;
    #1;
    chk("s2_idle_awvalid", o_awvalid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_aw($sformatf("s2_stall%0d", i), 1'b1, 4'b0000, awp(0));
    end
    tick();
    o_awready = 1'b1;
    #1;
    chk_aw("s2_hs0", 1'b1, 4'b0001, awp(0));
    tick();
    chk("s2_idle2_awvalid", o_awvalid, 1'b0);
    tick();
    chk_aw("s2_grant2", 1'b1, 4'b0100, awp(2));
    tick();
    i_awvalid = '0;
    do_srst();

    // FIFO full: fifth AW blocked; a pop in the IDLE cycle does not unblock it.
    i_awvalid = 4'hF; o_awready = 1'b1; i_wvalid = 4'b0001; i_wlast = 4'b0001; o_wready = 1'b0;
    repeat (8) tick();
    chk("s3_count_full", dut.r_count, 3'd4);
    chk("s3_full_awvalid", o_awvalid, 1'b0);
    chk_w("s3_head_stall", 1'b1, 4'b0000, 1'b1, wp(0));
    tick();
    o_wready = 1'b1;
    #1;
    chk("s3_full_awvalid2", o_awvalid, 1'b0);
    chk("s3_pop_wready", i_wready, 4'b0001);
    tick();
    o_wready = 1'b0;
    #1;
    chk("s3_pop_no_unblock", o_awvalid, 1'b0);
    chk("s3_count_after_pop", dut.r_count, 3'd3);
    tick();
    chk_aw("s3_fifth_lock", 1'b1, 4'b0001, awp(0));
    tick();
    i_awvalid = '0;
    do_srst();

    // Master 1 AW then master 3 AW; master 3 W waits for master 1's 4-beat burst.
    i_awvalid = 4'b0010; o_awready = 1'b1; o_wready = 1'b1; i_wvalid = 4'b1000; i_wlast = 4'b1000;
    #1;
    tick();
    chk_aw("s4_aw1", 1'b1, 4'b0010, awp(1));
    tick();
    i_awvalid = 4'b1000;
    #1;
    chk_w("s4_m3_blocked", 1'b0, 4'b0010, 1'b0, wp(1));
    tick();
    chk_aw("s4_aw3", 1'b1, 4'b1000, awp(3));
    chk("s4_m3_blocked2", o_wvalid, 1'b0);
    tick();
    i_awvalid = '0;
    #1;
    chk("s4_m3_blocked3", o_wvalid, 1'b0);
    for (int b = 0; b < 4; b++) begin
      tick();
      i_wvalid = 4'b1010;
      i_wlast  = (b == 3) ? 4'b1010 : 4'b1000;
      #1;
      chk_w($sformatf("s4_m1_beat%0d", b), 1'b1, 4'b0010, (b == 3), wp(1));
    end
    tick();
    i_wvalid = 4'b1000; i_wlast = 4'b1000;
    #1;
    chk_w("s4_m3_fwd", 1'b1, 4'b1000, 1'b1, wp(3));
    tick();
    i_wvalid = '0;
    #1;
    chk("s4_empty", o_wvalid, 1'b0);
    do_areset();

    // AW handshake coincident with head pop at count 1.
    i_awvalid = 4'b0001; o_awready = 1'b1;
    #1;
    tick();
    tick();
    i_awvalid = 4'b0100;
    #1;
    chk("s5_count1", dut.r_count, 3'd1);
    tick();
    i_wvalid = 4'b0001; i_wlast = 4'b0001; o_wready = 1'b1;
    #1;
    chk_aw("s5_aw2", 1'b1, 4'b0100, awp(2));
    chk_w("s5_pop0", 1'b1, 4'b0001, 1'b1, wp(0));
    tick();
    i_awvalid = '0; i_wvalid = 4'b0100; i_wlast = 4'b0100; o_wready = 1'b0;
    #1;
    chk("s5_count_still1", dut.r_count, 3'd1);
    chk_w("s5_new_head2", 1'b1, 4'b0000, 1'b1, wp(2));
    do_srst();

    // srst while LOCKED with two entries pending.
    i_awvalid = 4'hF; o_awready = 1'b1; o_wready = 1'b0;
    #1;
    repeat (5) tick();
    chk_aw("s6_locked2", 1'b1, 4'b0100, awp(2));
    chk("s6_count2", dut.r_count, 3'd2);
    o_awready = 1'b0; srst = 1'b1;
    i_wvalid = 4'hF; i_wlast = 4'hF; o_wready = 1'b1;
    tick();
    srst = 1'b0; o_awready = 1'b1;
    #1;
    chk_aw("s6_after_srst", 1'b0, 4'b0000, 64'h0);
    chk_w("s6_after_srst", 1'b0, 4'b0000, 1'b0, 72'h0);
    chk("s6_count0", dut.r_count, 3'd0);
    tick();
    chk_aw("s6_regrant0", 1'b1, 4'b0001, awp(0));
    tick();
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axicb_wr_arbiter.md
# axicb_wr_arbiter

Write-path arbitration stage for one crossbar slave port: arbitrates AW requests from MST_NB masters via an internal round-robin core, locks the winner until its AW handshake completes, and records each accepted master index in a routing FIFO. The FIFO then steers that master's W beats to the slave in AW acceptance order. Sits between the master-side AW/W pipelines and the slave-side output channels.

## Interface

- MST_NB, 4: number of masters; only 4 or 8 supported.
- AWCH_W, 64: AW payload width per master (addr, len, id, ...).
- WCH_W, 72: W payload width per master, excluding wlast.
- MST_OSTDREQ_NUM, 4: routing FIFO depth (power of 2, ≥2); maximum accepted AW whose W burst is not complete.
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- srst  in  1  synchronous reset, active-high; same effect as aresetn.
- i_awvalid  in  MST_NB  per-master AW valid.
- i_awready  out  MST_NB  per-master AW ready.
- i_awch  in  MST_NB*AWCH_W  AW payloads; master k at [k*AWCH_W +: AWCH_W].
- o_awvalid  out  1  slave AW valid.
- o_awready  in  1  slave AW ready.
- o_awch  out  AWCH_W  selected AW payload.
- i_wvalid  in  MST_NB  per-master W valid.
- i_wready  out  MST_NB  per-master W ready.
- i_wlast  in  MST_NB  per-master W last.
- i_wch  in  MST_NB*WCH_W  W payloads, same packing as AW.
- o_wvalid  out  1  slave W valid.
- o_wready  in  1  slave W ready.
- o_wlast  out  1  selected W last.
- o_wch  out  WCH_W  selected W payload.

## Operation

- AW FSM, two states: IDLE, LOCKED. Reset state IDLE.
- IDLE: round-robin req = i_awvalid. If grant nonzero and FIFO not full: register grant one-hot as sel, pulse the core's en (mask rotates), go LOCKED. If FIFO full: en=0, no latch, stay IDLE.
- LOCKED: o_awvalid = i_awvalid[sel]; o_awch = payload of sel; i_awready[sel] = o_awready; all other i_awready = 0. On o_awvalid && o_awready: push binary index of sel into FIFO, go IDLE.
- IDLE drives o_awvalid=0 and i_awready=0 on all masters; no combinational valid→ready path master-to-master.
- A master dropping awvalid while LOCKED (AXI violation) leaves the lock held; no timeout.
- W routing: FIFO head index h selects the master. If FIFO nonempty: o_wvalid = i_wvalid[h], o_wch/o_wlast from h, i_wready[h] = o_wready, other i_wready = 0. Empty: o_wvalid=0, all i_wready=0.
- Pop on o_wvalid && o_wready && o_wlast. Push and pop in the same cycle are both honoured; count unchanged.
- FIFO count width clog2(MST_OSTDREQ_NUM)+1; pointers wrap modulo depth.
- srst or aresetn: FSM IDLE, sel=0, FIFO emptied, round-robin mask all ones. Mid-burst reset discards pending routing; upstream must be reset with the same source.

## Timing

- All outputs 0 after reset.
- AW latency: arbitration cycle (IDLE) + ≥1 LOCKED cycle. o_awvalid rises 1 cycle after i_awvalid is seen in IDLE. Minimum AW issue interval: 2 cycles.
- W: no bypass. First beat can be forwarded 1 cycle after AW handshake (FIFO registered). Beats then stream 1/cycle while o_wready=1.
- Full check uses the registered count at the IDLE cycle. A pop in that same cycle does not unblock it.
- Fairness: grant order follows the core's rotating mask. With all requesting: 0,1,2,3,0 (MST_NB=4).

## Structure

- Shared package axicb_pkg: sel/index width function, FSM state enum (IDLE, LOCKED).
- Sub-module: one instance of axicb_round_robin_core (REQ_NB=MST_NB), driven by req/en; grant consumed only in IDLE.
- FIFO and muxes inline; no separate FIFO module.

## Test plan

- All 4 masters hold awvalid, o_awready=1, single-beat W each → AW order 0,1,2,3,0; W order matches; one AW per 2 cycles.
- Requests 4'b0101, o_awready low 3 cycles while LOCKED on master 0 → o_awvalid held with master 0 payload; i_awready[2]=0 throughout; then grant 2.
- MST_OSTDREQ_NUM=4, 4 AW accepted, o_wready=0 → 5th AW never locks (o_awvalid=0). wlast accepted on head → 5th locks next IDLE.
- Master 1 AW then master 3 AW; master 3 W presents first → o_wvalid=0 until master 1's 4-beat burst (wlast on beat 4) completes, then master 3 forwarded.
- AW handshake coincident with head pop when count=1 → count stays 1; new head is the new index next cycle.
- srst asserted in LOCKED with FIFO count 2 → next cycle all outputs 0, IDLE, FIFO empty; next grant starts from master 0.
